// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a five-stage MIPS-style pipeline: operand forwarding, load-use and
// branch-operand stalls, exception flushes and a multi-cycle divider interlock.
module pipeline_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              div_busy,
    output logic              div_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic [7:0]        CNT_LOAD = 8'(DIV_LAT - 2);

    div_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       lwstall_s;
    logic       brstall_s;
    logic       br_e_hit_s;
    logic       br_m_hit_s;
    logic       div_busy_s;

    // E-stage operand select: the younger result in M wins over W.
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if ((rsE != ZERO_REG) && (rsE == writeregM) && regwriteM) begin
            forwardaE = 2'b10;
        end else if ((rsE != ZERO_REG) && (rsE == writeregW) && regwriteW) begin
            forwardaE = 2'b01;
        end else begin
            forwardaE = 2'b00;
        end
        if ((rtE != ZERO_REG) && (rtE == writeregM) && regwriteM) begin
            forwardbE = 2'b10;
        end else if ((rtE != ZERO_REG) && (rtE == writeregW) && regwriteW) begin
            forwardbE = 2'b01;
        end else begin
            forwardbE = 2'b00;
        end
    end

    // D-stage comparator operands and the load-use / branch-operand stall causes.
    always_comb begin
        forwardaD  = (rsD != ZERO_REG) && (rsD == writeregM) && regwriteM;
        forwardbD  = (rtD != ZERO_REG) && (rtD == writeregM) && regwriteM;
        lwstall_s  = memtoregE && regwriteE && (writeregE != ZERO_REG) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        br_e_hit_s = regwriteE && (writeregE != ZERO_REG) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        // A load still in M cannot be forwarded to the branch comparator yet.
        br_m_hit_s = memtoregM && (writeregM != ZERO_REG) &&
                     ((writeregM == rsD) || (writeregM == rtD));
        brstall_s  = (branchD || jrD) && (br_e_hit_s || br_m_hit_s);
    end

    // Divider sequencer next state; an exception always abandons the divide.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exceptM) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (divE) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = cnt_q;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_DONE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Divider state and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The busy flag covers the issue cycle so the pipeline freezes immediately.
    always_comb begin
        div_busy_s = (state_q == S_BUSY) ||
                     ((state_q == S_IDLE) && divE && !exceptM);
        div_busy   = !rst && div_busy_s;
        div_done   = !rst && (state_q == S_DONE);
    end

    // Stall/flush resolution: exception, then divider, then data hazards.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (exceptM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (div_busy_s) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstall_s || brstall_s) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            stallF = 1'b0;
        end
    end

endmodule
